// File: rtl/result_drain_buffer.sv
// Row FIFO plus serializer draining array result rows as tagged 32-bit words.
// Optional ZERO_SKIP_EN suppresses words whose two elements are both zero.
module result_drain_buffer #(
  parameter int ARR_SIZE = 4,
  parameter int DEPTH    = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic [ARR_SIZE*16-1:0] row_in,
  input  logic                  row_valid,
  output logic                  row_ready,
  output logic [31:0]           data_out,
  output logic [6:0]            addr_out,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  idle
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int NW = ARR_SIZE / 2;
  localparam int KW = (NW > 1) ? $clog2(NW) : 1;
  localparam int RW = ARR_SIZE * 16;
  localparam logic [KW-1:0] K_LAST = KW'(NW - 1);

`ifdef ZERO_SKIP_EN
  localparam bit ZS = 1'b1;
`else
  localparam bit ZS = 1'b0;
`endif

  if (ARR_SIZE < 2 || (ARR_SIZE % 2) != 0) begin : g_bad_arr
    $error("ARR_SIZE must be even and >= 2");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("DEPTH must be a power of two >= 2");
  end

  typedef enum logic {
    S_IDLE,
    S_SEND
  } state_t;

  function automatic logic [31:0] word_of(
    input logic [RW-1:0] r,
    input logic [KW-1:0] k
  );
    return r[32*int'(k) +: 32];
  endfunction

  function automatic logic [6:0] addr_of(
    input logic [6:0]    rc,
    input logic [KW-1:0] k
  );
    int t;
    t = int'(rc) * ARR_SIZE + 2 * int'(k);
    return 7'(t);
  endfunction

  state_t          state_q, state_d;
  logic [RW-1:0]   mem_q [DEPTH];
  logic [AW-1:0]   wr_q, wr_d;
  logic [AW-1:0]   rd_q, rd_d;
  logic [AW:0]     cnt_q, cnt_d;
  logic [RW-1:0]   sh_q, sh_d;
  logic [KW-1:0]   k_q, k_d;
  logic [6:0]      rc_q, rc_d;
  logic [31:0]     dat_q, dat_d;
  logic [6:0]      adr_q, adr_d;

  logic            push;
  logic            pop;
  logic            skip;
  logic            adv;
  logic            last;
  logic [KW-1:0]   nk;
  logic [RW-1:0]   head;

  assign row_ready = (cnt_q < (AW+1)'(DEPTH)) && !clr;
  assign push      = row_valid && row_ready;
  assign head      = mem_q[rd_q];
  assign last      = (k_q == K_LAST);

  // A skipped word still costs one cycle so addresses advance uniformly.
  assign skip      = ZS && (state_q == S_SEND) && (dat_q == 32'd0);
  assign out_valid = (state_q == S_SEND) && !skip;
  assign adv       = (state_q == S_SEND) &&
                     ((out_valid && out_ready) || skip);

  assign data_out  = dat_q;
  assign addr_out  = adr_q;
  assign idle      = (cnt_q == '0) && (state_q == S_IDLE);

  always_comb begin
    state_d = state_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    k_d     = k_q;
    rc_d    = rc_q;
    dat_d   = dat_q;
    adr_d   = adr_q;
    pop     = 1'b0;
    nk      = k_q + KW'(1);
    if (clr) begin
      state_d = S_IDLE;
      wr_d    = '0;
      rd_d    = '0;
      cnt_d   = '0;
      k_d     = '0;
      rc_d    = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (cnt_q != '0) begin
            pop     = 1'b1;
            state_d = S_SEND;
          end
        end
        S_SEND: begin
          if (adv) begin
            if (last) begin
              rc_d = rc_q + 7'd1;
              if (cnt_q != '0) begin
                pop = 1'b1;
              end else begin
                state_d = S_IDLE;
              end
            end else begin
              k_d   = nk;
              dat_d = word_of(sh_q, nk);
              adr_d = addr_of(rc_q, nk);
            end
          end
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
      if (pop) begin
        sh_d  = head;
        k_d   = '0;
        dat_d = word_of(head, '0);
        adr_d = addr_of(rc_d, '0);
        rd_d  = rd_q + AW'(1);
      end
      if (push) begin
        wr_d = wr_q + AW'(1);
      end
      cnt_d = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      wr_q    <= '0;
      rd_q    <= '0;
      cnt_q   <= '0;
      sh_q    <= '0;
      k_q     <= '0;
      rc_q    <= '0;
      dat_q   <= '0;
      adr_q   <= '0;
    end else begin
      state_q <= state_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      cnt_q   <= cnt_d;
      sh_q    <= sh_d;
      k_q     <= k_d;
      rc_q    <= rc_d;
      dat_q   <= dat_d;
      adr_q   <= adr_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (push) begin
      mem_q[wr_q] <= row_in;
    end
  end

endmodule
